sram_axi_arbiter: RTL and testbench
===================================

# sram_axi_arbiter

Bridges the CPU's two SRAM-style request ports (instruction fetch and data load/store) onto one AXI3 master interface. Arbitrates reads between the two sources and sequences the AR/R, AW/W/B channels. Keeps at most one read and one write in flight. Sits between the pipeline front/back ends and the AXI memory slave.

## Interface
Parameters:
- none (IDs fixed: instruction read = 0, data read = 1, write = 1)

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  fetch request; wr is always 0 from IF
- inst_sram_addr_ok  out  1  fetch request accepted this cycle
- inst_sram_data_ok  out  1  fetch data valid this cycle
- inst_sram_rdata  out  32  fetch data
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  load (wr=0) or store (wr=1) request
- data_sram_addr_ok / data_sram_data_ok  out  1/1  data-port accept / completion
- data_sram_rdata  out  32  load data
- arid/araddr/arsize/arvalid  out  4/32/3/1, arready in 1  read address channel
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1, rready out 1  read data channel
- awid/awaddr/awsize/awvalid  out  4/32/3/1, awready in 1  write address channel
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1, wready in 1  write data channel
- bid/bresp/bvalid  in  4/2/1, bready out 1  write response channel
- constant outputs: arlen=awlen=0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, wlast=1, wid=1, awid=1

## Operation
- Read FSM: R_IDLE -> R_AR -> R_WAIT -> R_IDLE.
  - R_IDLE: data read takes priority over fetch. Data read is accepted only when the write FSM is in W_IDLE.
  - Accept in R_IDLE: addr_ok=1 for the winner. Latch addr, size, and id (0 for fetch, 1 for data). Go to R_AR.
  - R_AR: arvalid=1 holds stable until arready; then go to R_WAIT.
  - R_WAIT: rready=1. On rvalid, pulse data_ok to the port selected by rid[0]. rdata passes combinationally to both *_rdata. Go to R_IDLE.
- Write FSM: W_IDLE -> W_REQ -> W_B -> W_IDLE.
  - W_IDLE: a data write is accepted (data_sram_addr_ok=1) only when the read FSM holds no data read (R_IDLE or latched id=0). Latch awaddr, awsize, wdata, wstrb. Go to W_REQ.
  - W_REQ: awvalid and wvalid both rise. Each drops independently on its own handshake. Move to W_B once both handshakes have occurred (same or different cycles).
  - W_B: bready=1. On bvalid, pulse data_sram_data_ok and go to W_IDLE.
- Ordering:
  - A data read never overtakes a pending write.
  - A data write never overlaps a pending data read, so the data port never gets two data_ok in one cycle.
  - Fetch reads are not ordered against writes.
- Width rules:
  - arsize/awsize = {1'b0, size}.
  - rresp/bresp are ignored.
  - Any rid/bid value other than the latched one is not expected; rid[0] alone selects the destination port.
- A data-port request with wr=1 is never granted through the read path, and vice versa.
- addr_ok is combinational from req and FSM state. A request not accepted must be held by the requester.

## Timing
- Reset values: arvalid, awvalid, wvalid, rready, bready, all addr_ok, all data_ok = 0. araddr/awaddr/wdata/wstrb = 0. Both FSMs idle.
- Reset asserted mid-transaction returns both FSMs to idle immediately. Outstanding AXI beats are dropped; the slave is reset with the CPU.
- Best-case read: addr_ok in cycle 0, arvalid cycle 1, R_WAIT cycle 2, data_ok in cycle 2 if rvalid is already high. That is 2 cycles from accept to data.
- Best-case write: addr_ok cycle 0, aw/w handshake cycle 1, bready cycle 2, data_ok in cycle 2.
- Next read is accepted earliest in the cycle after data_ok (R_IDLE re-entered). Same rule applies for writes.
- Simultaneous inst and data read requests in R_IDLE: the data read wins, and the fetch addr_ok stays 0 that cycle.
- A data read and a data write cannot both be requested on the one data port in the same cycle.
- awready and wready in different cycles: the side already accepted deasserts its valid next cycle, and the other keeps waiting.

## Test plan
- Single fetch: inst req addr=0x1C000000; arready=1, rvalid one cycle later with rdata=0x02800C06 -> arid=0, inst_data_ok pulse, inst_rdata=0x02800C06, data_ok=0.
- Conflict: inst and data read both requested in cycle 0 -> data_addr_ok=1, inst_addr_ok=0. The fetch is accepted in the cycle after the data read's data_ok, with arid=0.
- Store then load: write to 0x1C001000 with wstrb=4'hF, bvalid delayed 5 cycles; load requested meanwhile -> data_addr_ok for the load stays 0 until the cycle after the write's data_ok.
- Split handshake: awready in cycle 1, wready in cycle 4 -> awvalid low from cycle 2, wvalid high through cycle 4, bready from cycle 5.
- Back-pressure: arready held 0 for 3 cycles -> araddr/arid/arsize stable and arvalid high for 4 cycles.
- Reset mid-read: assert reset while in R_WAIT -> all valids, readys and ok outputs go 0 asynchronously. After release, a fetch is accepted immediately.

Source files
------------

// File: rtl/sram_axi_if.sv
// rtl/sram_axi_if.sv - CPU SRAM-style request ports plus AXI3 master channels
interface sram_axi_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_arbiter.sv
// rtl/sram_axi_arbiter.sv - fetch/data SRAM ports onto one AXI3 master, one read and one write in flight
module sram_axi_arbiter (
    input  logic          clk,
    input  logic          reset,
    sram_axi_if.master    bus
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t    r_state_q, r_state_d;
    logic        rsel_q, rsel_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  arsize_q, arsize_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;

    w_state_t    w_state_q, w_state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [1:0]  awsize_q, awsize_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    logic data_rd_grant, inst_rd_grant, data_wr_grant;
    logic data_read_busy, r_done, b_done;

    // A data read waits for the write path to drain; a write waits for any data read.
    always_comb begin
        data_read_busy = (r_state_q != R_IDLE) && rsel_q;
        data_rd_grant  = !reset && (r_state_q == R_IDLE) && bus.data_sram_req
                         && !bus.data_sram_wr && (w_state_q == W_IDLE);
        inst_rd_grant  = !reset && (r_state_q == R_IDLE) && bus.inst_sram_req && !data_rd_grant;
        data_wr_grant  = !reset && (w_state_q == W_IDLE) && bus.data_sram_req
                         && bus.data_sram_wr && !data_read_busy;
        r_done         = !reset && (r_state_q == R_WAIT) && bus.rvalid;
        b_done         = !reset && (w_state_q == W_B) && bus.bvalid;
    end

    always_comb begin
        r_state_d = r_state_q;
        rsel_d    = rsel_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_grant || inst_rd_grant) begin
                    r_state_d = R_AR;
                    rsel_d    = data_rd_grant;
                    araddr_d  = data_rd_grant ? bus.data_sram_addr : bus.inst_sram_addr;
                    arsize_d  = data_rd_grant ? bus.data_sram_size : bus.inst_sram_size;
                end
            end
            R_AR:    if (bus.arready) r_state_d = R_WAIT;
            R_WAIT:  if (bus.rvalid) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        arvalid_d = (r_state_d == R_AR);
        rready_d  = (r_state_d == R_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rsel_q    <= 1'b0;
            araddr_q  <= 32'd0;
            arsize_q  <= 2'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rsel_q    <= rsel_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    // AW and W complete independently; leave W_REQ once both valids have dropped.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_grant) begin
                    w_state_d = W_REQ;
                    awaddr_d  = bus.data_sram_addr;
                    awsize_d  = bus.data_sram_size;
                    wdata_d   = bus.data_sram_wdata;
                    wstrb_d   = bus.data_sram_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            W_REQ: begin
                if (bus.awready) awvalid_d = 1'b0;
                if (bus.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) w_state_d = W_B;
            end
            W_B:     if (bus.bvalid) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        bready_d = (w_state_d == W_B);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= 32'd0;
            awsize_q  <= 2'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign bus.inst_sram_addr_ok = inst_rd_grant;
    assign bus.data_sram_addr_ok = data_rd_grant || data_wr_grant;
    assign bus.inst_sram_data_ok = r_done && !bus.rid[0];
    assign bus.data_sram_data_ok = (r_done && bus.rid[0]) || b_done;
    assign bus.inst_sram_rdata   = bus.rdata;
    assign bus.data_sram_rdata   = bus.rdata;

    assign bus.arid    = {3'b000, rsel_q};
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 4'd0;
    assign bus.arsize  = {1'b0, arsize_q};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'd0;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    assign bus.awid    = 4'd1;
    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = 4'd0;
    assign bus.awsize  = {1'b0, awsize_q};
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'd0;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awvalid = awvalid_q;

    assign bus.wid     = 4'd1;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;

    logic unused_inputs;
    assign unused_inputs = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                             bus.rid[3:1], bus.rresp, bus.rlast, bus.bid, bus.bresp};

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb/tb_sram_axi_arbiter.sv - directed and random transactions against a word-memory reference model
module tb_sram_axi_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    sram_axi_if bus ();

    sram_axi_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] v;
        v = model_rd(a);
        for (int i = 0; i < 4; i++)
            if (st[i]) v[8*i +: 8] = d[8*i +: 8];
        mem[a] = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue_read(input bit is_data, input logic [31:0] a, input logic [1:0] sz);
        int n;
        @(negedge clk);
        if (is_data) begin
            bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0;
            bus.data_sram_addr = a;   bus.data_sram_size = sz;
        end else begin
            bus.inst_sram_req = 1'b1; bus.inst_sram_addr = a; bus.inst_sram_size = sz;
        end
        #1;
        n = 0;
        while ((is_data ? bus.data_sram_addr_ok : bus.inst_sram_addr_ok) !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk(is_data ? "rd_data_addr_ok" : "rd_inst_addr_ok",
            is_data ? bus.data_sram_addr_ok : bus.inst_sram_addr_ok, 1);
    endtask

    task automatic finish_read(input bit is_data, input logic [31:0] a, input logic [1:0] sz,
                               input int ard, input int rd);
        logic [31:0] rv;
        rv = model_rd(a);
        @(negedge clk);
        if (is_data) begin
            bus.data_sram_req = 1'b0; bus.data_sram_addr = ~a;
        end else begin
            bus.inst_sram_req = 1'b0; bus.inst_sram_addr = ~a;
        end
        for (int c = 0; c <= ard; c++) begin
            bus.arready = (c == ard);
            #1;
            chk("arvalid", bus.arvalid, 1);
            chk("araddr", bus.araddr, a);
            chk("arid", bus.arid, {3'b000, is_data});
            chk("arsize", bus.arsize, {1'b0, sz});
            chk("rready_in_ar", bus.rready, 0);
            chk("inst_addr_ok_busy", bus.inst_sram_addr_ok, 0);
            @(negedge clk);
        end
        bus.arready = 1'b0;
        for (int c = 0; c < rd; c++) begin
            #1;
            chk("rready", bus.rready, 1);
            chk("arvalid_after_hs", bus.arvalid, 0);
            chk("data_ok_early", {bus.inst_sram_data_ok, bus.data_sram_data_ok}, 0);
            @(negedge clk);
        end
        bus.rvalid = 1'b1; bus.rid = {3'b000, is_data}; bus.rdata = rv;
        bus.rresp = 2'b00; bus.rlast = 1'b1;
        #1;
        chk("rready_beat", bus.rready, 1);
        chk("inst_data_ok", bus.inst_sram_data_ok, !is_data);
        chk("data_data_ok", bus.data_sram_data_ok, is_data);
        chk("rdata", is_data ? bus.data_sram_rdata : bus.inst_sram_rdata, rv);
        chk("inst_addr_ok_beat", bus.inst_sram_addr_ok, 0);
        @(negedge clk);
        bus.rvalid = 1'b0; bus.rid = 4'd0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input logic [1:0] sz, input int awd, input int wd, input int bd,
                            input bit hold_load, input logic [31:0] la);
        int n;
        int last;
        @(negedge clk);
        bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = a;
        bus.data_sram_wdata = d;  bus.data_sram_wstrb = st; bus.data_sram_size = sz;
        #1;
        n = 0;
        while (bus.data_sram_addr_ok !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("wr_addr_ok", bus.data_sram_addr_ok, 1);
        model_wr(a, d, st);
        @(negedge clk);
        bus.data_sram_wdata = ~d; bus.data_sram_wstrb = ~st;
        if (hold_load) begin
            bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0;
            bus.data_sram_addr = la;  bus.data_sram_size = 2'd2;
        end else begin
            bus.data_sram_req = 1'b0; bus.data_sram_wr = 1'b0; bus.data_sram_addr = ~a;
        end
        last = (awd > wd) ? awd : wd;
        for (int c = 0; c <= last; c++) begin
            bus.awready = (c == awd);
            bus.wready  = (c == wd);
            #1;
            chk("awvalid", bus.awvalid, (c <= awd));
            chk("wvalid", bus.wvalid, (c <= wd));
            chk("bready_early", bus.bready, 0);
            chk("load_blocked_req", bus.data_sram_addr_ok, 0);
            if (c == 0) begin
                chk("awaddr", bus.awaddr, a);
                chk("awsize", bus.awsize, {1'b0, sz});
                chk("wdata", bus.wdata, d);
                chk("wstrb", bus.wstrb, st);
                chk("awid_wid_wlast", {bus.awid, bus.wid, bus.wlast}, {4'd1, 4'd1, 1'b1});
            end
            @(negedge clk);
        end
        bus.awready = 1'b0; bus.wready = 1'b0;
        for (int c = 0; c < bd; c++) begin
            #1;
            chk("bready", bus.bready, 1);
            chk("wr_data_ok_early", bus.data_sram_data_ok, 0);
            chk("load_blocked_b", bus.data_sram_addr_ok, 0);
            @(negedge clk);
        end
        bus.bvalid = 1'b1; bus.bid = 4'd1; bus.bresp = 2'b00;
        #1;
        chk("bready_beat", bus.bready, 1);
        chk("wr_data_ok", bus.data_sram_data_ok, 1);
        chk("wr_inst_data_ok", bus.inst_sram_data_ok, 0);
        chk("load_blocked_beat", bus.data_sram_addr_ok, 0);
        @(negedge clk);
        bus.bvalid = 1'b0; bus.bid = 4'd0;
        if (hold_load) begin
            #1;
            chk("load_after_store_ok", bus.data_sram_addr_ok, 1);
        end
    endtask

    int          op;
    logic [31:0] ra;
    logic [31:0] rd_word;
    logic [1:0]  rsz;
    logic [3:0]  rst4;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1;
        bus.inst_sram_req = 0; bus.inst_sram_wr = 0; bus.inst_sram_size = 0;
        bus.inst_sram_wstrb = 0; bus.inst_sram_addr = 0; bus.inst_sram_wdata = 0;
        bus.data_sram_req = 0; bus.data_sram_wr = 0; bus.data_sram_size = 0;
        bus.data_sram_wstrb = 0; bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;

        repeat (2) @(negedge clk);
        bus.inst_sram_req = 1'b1;
        #1;
        chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid}, 0);
        chk("rst_readys", {bus.rready, bus.bready}, 0);
        chk("rst_oks", {bus.inst_sram_addr_ok, bus.data_sram_addr_ok,
                        bus.inst_sram_data_ok, bus.data_sram_data_ok}, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_wstrb", bus.wstrb, 0);
        chk("const_len_burst", {bus.arlen, bus.awlen, bus.arburst, bus.awburst}, {8'd0, 4'b0101});
        @(negedge clk);
        reset = 1'b0; bus.inst_sram_req = 1'b0;

        // Single fetch
        mem[32'h1C00_0000] = 32'h0280_0C06;
        issue_read(0, 32'h1C00_0000, 2'd2);
        finish_read(0, 32'h1C00_0000, 2'd2, 0, 0);

        // Fetch and load requested together: load first, fetch right after its data_ok
        @(negedge clk);
        bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0040; bus.inst_sram_size = 2'd2;
        bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0;
        bus.data_sram_addr = 32'h1C00_0080; bus.data_sram_size = 2'd2;
        #1;
        chk("conflict_data_ok", bus.data_sram_addr_ok, 1);
        chk("conflict_inst_ok", bus.inst_sram_addr_ok, 0);
        finish_read(1, 32'h1C00_0080, 2'd2, 0, 0);
        #1;
        chk("conflict_fetch_next", bus.inst_sram_addr_ok, 1);
        finish_read(0, 32'h1C00_0040, 2'd2, 0, 0);

        // Store then load to the same word, bvalid late
        do_write(32'h1C00_1000, 32'h1234_5678, 4'hF, 2'd2, 0, 0, 5, 1, 32'h1C00_1000);
        finish_read(1, 32'h1C00_1000, 2'd2, 0, 0);

        // Split AW/W handshake
        do_write(32'h1C00_2000, 32'hCAFE_F00D, 4'h3, 2'd1, 0, 3, 0, 0, 32'd0);

        // Read back-pressure on AR
        issue_read(0, 32'h1C00_0100, 2'd2);
        finish_read(0, 32'h1C00_0100, 2'd2, 3, 2);

        // Reset while waiting for R
        issue_read(0, 32'h1C00_0200, 2'd2);
        @(negedge clk);
        bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
        #1;
        chk("rst_mid_arvalid", bus.arvalid, 1);
        @(negedge clk);
        bus.arready = 1'b0;
        #1;
        chk("rst_mid_in_wait", bus.rready, 1);
        #2;
        reset = 1'b1; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.inst_sram_req = 1'b1;
        #1;
        chk("rst_mid_rready", bus.rready, 0);
        chk("rst_mid_arvalid0", bus.arvalid, 0);
        chk("rst_mid_oks", {bus.inst_sram_addr_ok, bus.data_sram_addr_ok,
                            bus.inst_sram_data_ok, bus.data_sram_data_ok}, 0);
        @(negedge clk);
        reset = 1'b0; bus.rvalid = 1'b0;
        bus.inst_sram_addr = 32'h1C00_0204; bus.inst_sram_size = 2'd2;
        #1;
        chk("rst_release_fetch_ok", bus.inst_sram_addr_ok, 1);
        finish_read(0, 32'h1C00_0204, 2'd2, 1, 1);

        // Random mix of fetches, loads and stores over a small address window
        for (int i = 0; i < 24; i++) begin
            op  = $urandom_range(0, 2);
            ra  = 32'h1C00_0000 + ($urandom_range(0, 7) << 2);
            rsz = 2'($urandom_range(0, 2));
            case (op)
                0: begin
                    issue_read(0, ra, rsz);
                    finish_read(0, ra, rsz, $urandom_range(0, 3), $urandom_range(0, 3));
                end
                1: begin
                    issue_read(1, ra, rsz);
                    finish_read(1, ra, rsz, $urandom_range(0, 3), $urandom_range(0, 3));
                end
                default: begin
                    rd_word = $urandom;
                    rst4    = 4'($urandom_range(1, 15));
                    do_write(ra, rd_word, rst4, rsz, $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 3), 0, 32'd0);
                end
            endcase
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
